// File: rtl/pc_pkg.sv
// -----------------------------------------------------------------------------
// pc_pkg
// Shared types and constants for the PC / return-address-stack unit.
//   pc_op_t    : 3-bit encoded next-PC operation selector
//   INST_BYTES : fixed instruction size, used to form the link value pc+4
// -----------------------------------------------------------------------------
package pc_pkg;

  typedef enum logic [2:0] {
    NEXT = 3'd0,
    JAL  = 3'd1,
    JALR = 3'd2,
    BEQ  = 3'd3,
    BNE  = 3'd4,
    BLT  = 3'd5,
    BGE  = 3'd6
  } pc_op_t;

  localparam int INST_BYTES = 4;

endpackage : pc_pkg

// File: rtl/ras_stack.sv
// -----------------------------------------------------------------------------
// ras_stack
// Circular return-address stack. A push on a full stack overwrites the oldest
// entry while the count saturates; a pop on an empty stack does nothing.
// Ports:
//   clk, RST        : clock, synchronous active-high reset (clears count)
//   push            : write wdata as the new top entry
//   pop             : discard the top entry (ignored when empty)
//   replace         : overwrite the top entry with wdata; acts as push if empty
//   wdata [XLEN]    : value written by push/replace
//   top   [XLEN]    : current top entry, 0 when empty
//   count           : number of valid entries, 0..RAS_DEPTH
// The caller guarantees that at most one of push/pop/replace is high.
// -----------------------------------------------------------------------------
module ras_stack
  import pc_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         RST,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         replace,
  input  logic [XLEN-1:0]              wdata,
  output logic [XLEN-1:0]              top,
  output logic [$clog2(RAS_DEPTH):0]   count
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;

  logic [XLEN-1:0] mem_q [RAS_DEPTH];
  logic [PW-1:0]   ptr_q, ptr_d;       // index of the current top entry
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            wr_en_s;
  logic [PW-1:0]   wr_idx_s;
  logic            empty_s;
  logic            do_push_s;

  assign empty_s   = (cnt_q == {CW{1'b0}});
  // Replacing on an empty stack degenerates into an ordinary push.
  assign do_push_s = push | (replace & empty_s);

  // Next pointer/count and write-port selection.
  always_comb begin
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    wr_en_s  = 1'b0;
    wr_idx_s = ptr_q;
    if (do_push_s) begin
      // Pointer wraps naturally because RAS_DEPTH is a power of two, so a
      // push on a full stack lands on the oldest slot.
      ptr_d    = ptr_q + PW'(1);
      wr_en_s  = 1'b1;
      wr_idx_s = ptr_q + PW'(1);
      if (cnt_q != CW'(RAS_DEPTH)) begin
        cnt_d = cnt_q + CW'(1);
      end else begin
        cnt_d = cnt_q;
      end
    end else if (replace) begin
      wr_en_s  = 1'b1;
      wr_idx_s = ptr_q;
    end else if (pop && !empty_s) begin
      ptr_d = ptr_q - PW'(1);
      cnt_d = cnt_q - CW'(1);
    end else begin
      ptr_d = ptr_q;
      cnt_d = cnt_q;
    end
  end

  // Pointer and count registers; reset empties the stack.
  always_ff @(posedge clk) begin
    if (RST) begin
      ptr_q <= {PW{1'b0}};
      cnt_q <= {CW{1'b0}};
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  // Entry storage; contents need no reset, but writes during reset are dropped.
  always_ff @(posedge clk) begin
    if (wr_en_s && !RST) begin
      mem_q[wr_idx_s] <= wdata;
    end
  end

  assign top   = empty_s ? {XLEN{1'b0}} : mem_q[ptr_q];
  assign count = cnt_q;

endmodule : ras_stack

// File: rtl/pc_ras_unit.sv
// -----------------------------------------------------------------------------
// pc_ras_unit
// Program counter with branch/jump resolution and a return-address stack.
// Ports:
//   clk, RST            : clock, synchronous active-high reset
//   iready              : commit enable; pc and RAS advance only when high
//   op                  : next-PC operation (pc_op_t)
//   rs1_read, imm       : JALR base and sign-extended immediate
//   zero, negative      : ALU flags for branch resolution
//   rd_is_ra, rs1_is_ra : link-register hints that drive RAS push/pop
//   pc                  : current PC (registered)
//   pc_plus4            : link value pc+4 (combinational)
//   ras_top, ras_count  : RAS top entry (0 when empty) and occupancy
//   ras_hit             : registered pulse, last return matched prediction
//   misalign            : registered, last committed target not word aligned
// -----------------------------------------------------------------------------
module pc_ras_unit
  import pc_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = {XLEN{1'b0}},
  parameter int              RAS_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         RST,
  input  logic                         iready,
  input  pc_op_t                       op,
  input  logic [XLEN-1:0]              rs1_read,
  input  logic [XLEN-1:0]              imm,
  input  logic                         zero,
  input  logic                         negative,
  input  logic                         rd_is_ra,
  input  logic                         rs1_is_ra,
  output logic [XLEN-1:0]              pc,
  output logic [XLEN-1:0]              pc_plus4,
  output logic [XLEN-1:0]              ras_top,
  output logic [$clog2(RAS_DEPTH):0]   ras_count,
  output logic                         ras_hit,
  output logic                         misalign
);

  localparam int CW = $clog2(RAS_DEPTH) + 1;

  logic [XLEN-1:0] pc_q, pc_d;
  logic            ras_hit_q, ras_hit_d;
  logic            misalign_q, misalign_d;
  logic [XLEN-1:0] target_s;
  logic [XLEN-1:0] rel_tgt_s;
  logic [XLEN-1:0] jalr_sum_s;
  logic            is_jump_s;
  logic            is_jalr_s;
  logic            push_s, pop_s, replace_s;

  assign pc_plus4   = pc_q + XLEN'(INST_BYTES);
  assign rel_tgt_s  = pc_q + imm;
  assign jalr_sum_s = rs1_read + imm;

  // Target mux and branch resolution; unknown encodings fall through to pc+4.
  always_comb begin
    target_s = pc_plus4;
    case (op)
      NEXT:    target_s = pc_plus4;
      JAL:     target_s = rel_tgt_s;
      JALR:    target_s = {jalr_sum_s[XLEN-1:1], 1'b0};
      BEQ:     target_s = zero       ? rel_tgt_s : pc_plus4;
      BNE:     target_s = (!zero)    ? rel_tgt_s : pc_plus4;
      BLT:     target_s = negative   ? rel_tgt_s : pc_plus4;
      BGE:     target_s = (!negative) ? rel_tgt_s : pc_plus4;
      default: target_s = pc_plus4;
    endcase
  end

  assign is_jalr_s = (op == JALR);
  assign is_jump_s = (op == JAL) || is_jalr_s;

  // Call pushes the link; return pops; a JALR that is both return and call
  // (rd and rs1 both link registers) swaps the top entry for the new link.
  assign replace_s = iready & is_jalr_s & rs1_is_ra & rd_is_ra;
  assign push_s    = iready & is_jump_s & rd_is_ra & ~replace_s;
  assign pop_s     = iready & is_jalr_s & rs1_is_ra & ~rd_is_ra;

  // Next-state for pc and the status flags.
  always_comb begin
    pc_d       = pc_q;
    ras_hit_d  = 1'b0;
    misalign_d = misalign_q;
    if (iready) begin
      pc_d       = target_s;
      misalign_d = |target_s[1:0];
      ras_hit_d  = pop_s && (ras_count != {CW{1'b0}}) && (target_s == ras_top);
    end else begin
      pc_d       = pc_q;
      ras_hit_d  = 1'b0;
      misalign_d = misalign_q;
    end
  end

  // PC and status registers.
  always_ff @(posedge clk) begin
    if (RST) begin
      pc_q       <= RESET_VEC;
      ras_hit_q  <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      ras_hit_q  <= ras_hit_d;
      misalign_q <= misalign_d;
    end
  end

  ras_stack #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk     (clk),
    .RST     (RST),
    .push    (push_s),
    .pop     (pop_s),
    .replace (replace_s),
    .wdata   (pc_plus4),
    .top     (ras_top),
    .count   (ras_count)
  );

  assign pc       = pc_q;
  assign ras_hit  = ras_hit_q;
  assign misalign = misalign_q;

endmodule : pc_ras_unit

// File: tb/tb_pc_ras_unit.sv
// -----------------------------------------------------------------------------
// tb_pc_ras_unit
// Directed self-checking bench for pc_ras_unit at default parameters
// (XLEN=32, RESET_VEC=0, RAS_DEPTH=4).
// -----------------------------------------------------------------------------
module tb_pc_ras_unit;
  import pc_pkg::*;

  logic        clk;
  logic        RST;
  logic        iready;
  pc_op_t      op;
  logic [31:0] rs1_read;
  logic [31:0] imm;
  logic        zero;
  logic        negative;
  logic        rd_is_ra;
  logic        rs1_is_ra;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] ras_top;
  logic [2:0]  ras_count;
  logic        ras_hit;
  logic        misalign;

  int pass_cnt = 0;
  int total_cnt = 0;

  pc_ras_unit dut (
    .clk       (clk),
    .RST       (RST),
    .iready    (iready),
    .op        (op),
    .rs1_read  (rs1_read),
    .imm       (imm),
    .zero      (zero),
    .negative  (negative),
    .rd_is_ra  (rd_is_ra),
    .rs1_is_ra (rs1_is_ra),
    .pc        (pc),
    .pc_plus4  (pc_plus4),
    .ras_top   (ras_top),
    .ras_count (ras_count),
    .ras_hit   (ras_hit),
    .misalign  (misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one cycle of stimulus, then sample 1 time unit after the edge.
  task automatic drive(input pc_op_t o, input logic [31:0] im, input logic [31:0] r1,
                       input logic z, input logic n, input logic rd, input logic rs,
                       input logic rdy);
    op = o; imm = im; rs1_read = r1; zero = z; negative = n;
    rd_is_ra = rd; rs1_is_ra = rs; iready = rdy;
    @(posedge clk);
    #1;
  endtask

  // Jump to an absolute address with no RAS activity.
  task automatic goto(input logic [31:0] addr);
    drive(JALR, 32'h0, addr, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    total_cnt++;
    if (pc !== addr) $display("FAIL goto: pc=%h expected %h", pc, addr); else pass_cnt++;
  endtask

  task automatic test_reset();
    RST = 1'b1; iready = 1'b1; op = JAL; imm = 32'h40; rs1_read = 32'h0;
    zero = 1'b0; negative = 1'b0; rd_is_ra = 1'b1; rs1_is_ra = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      #1;
      total_cnt++;
      if (pc !== 32'h0) $display("FAIL reset_pc: pc=%h expected 0", pc); else pass_cnt++;
      total_cnt++;
      if (ras_count !== 3'd0) $display("FAIL reset_cnt: count=%0d expected 0", ras_count); else pass_cnt++;
      total_cnt++;
      if (ras_hit !== 1'b0) $display("FAIL reset_hit: hit=%b expected 0", ras_hit); else pass_cnt++;
    end
    RST = 1'b0;
    drive(JAL, 32'h40, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    total_cnt++;
    if (pc !== 32'h0 || ras_count !== 3'd0 || ras_hit !== 1'b0 || misalign !== 1'b0)
      $display("FAIL post_reset: pc=%h cnt=%0d hit=%b mis=%b expected 0/0/0/0",
               pc, ras_count, ras_hit, misalign);
    else pass_cnt++;
    // First commit uses pc=RESET_VEC.
    drive(NEXT, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    total_cnt++;
    if (pc !== 32'h4) $display("FAIL first_commit: pc=%h expected 4", pc); else pass_cnt++;
  endtask

  task automatic test_call_return();
    goto(32'h100);
    drive(JAL, 32'h40, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    total_cnt++;
    if (pc !== 32'h140 || ras_top !== 32'h104 || ras_count !== 3'd1)
      $display("FAIL call: pc=%h top=%h cnt=%0d expected 140/104/1", pc, ras_top, ras_count);
    else pass_cnt++;
    total_cnt++;
    if (pc_plus4 !== 32'h144) $display("FAIL pc_plus4: %h expected 144", pc_plus4); else pass_cnt++;
    drive(JALR, 32'h0, 32'h104, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    total_cnt++;
    if (pc !== 32'h104 || ras_count !== 3'd0 || ras_hit !== 1'b1)
      $display("FAIL return: pc=%h cnt=%0d hit=%b expected 104/0/1", pc, ras_count, ras_hit);
    else pass_cnt++;
    drive(NEXT, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    total_cnt++;
    if (ras_hit !== 1'b0 || pc !== 32'h104)
      $display("FAIL hit_pulse: hit=%b pc=%h expected 0/104", ras_hit, pc);
    else pass_cnt++;
  endtask

  task automatic test_branches();
    pc_op_t      ops  [9] = '{BEQ, BEQ, BNE, BNE, BLT, BLT, BGE, BGE, NEXT};
    logic        zs   [9] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic        ns   [9] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] exps [9] = '{32'h1F8, 32'h204, 32'h1F8, 32'h204,
                              32'h1F8, 32'h204, 32'h204, 32'h1F8, 32'h204};
    for (int i = 0; i < 9; i++) begin
      goto(32'h200);
      // Last entry uses an encoding outside the enumeration.
      if (i == 8) drive(pc_op_t'(3'd7), 32'hFFFF_FFF8, 32'h0, zs[i], ns[i], 1'b0, 1'b0, 1'b1);
      else        drive(ops[i],         32'hFFFF_FFF8, 32'h0, zs[i], ns[i], 1'b0, 1'b0, 1'b1);
      total_cnt++;
      if (pc !== exps[i]) $display("FAIL branch_%0d: pc=%h expected %h", i, pc, exps[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_ras_overflow();
    logic [31:0] links [4] = '{32'h1404, 32'h1304, 32'h1204, 32'h1104};
    logic [2:0]  ecnt;
    goto(32'h1000);
    for (int i = 0; i < 5; i++) begin
      drive(JAL, 32'h100, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      ecnt = (i < 4) ? 3'(i + 1) : 3'd4;
      total_cnt++;
      if (ras_count !== ecnt) $display("FAIL ovf_push_%0d: cnt=%0d expected %0d", i, ras_count, ecnt);
      else pass_cnt++;
    end
    for (int i = 0; i < 4; i++) begin
      total_cnt++;
      if (ras_top !== links[i]) $display("FAIL ovf_top_%0d: top=%h expected %h", i, ras_top, links[i]);
      else pass_cnt++;
      drive(JALR, 32'h0, links[i], 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      total_cnt++;
      if (ras_hit !== 1'b1 || ras_count !== 3'(3 - i) || pc !== links[i])
        $display("FAIL ovf_ret_%0d: hit=%b cnt=%0d pc=%h expected 1/%0d/%h",
                 i, ras_hit, ras_count, pc, 3 - i, links[i]);
      else pass_cnt++;
    end
    // Oldest link 0x1004 was overwritten; stack is empty now.
    drive(JALR, 32'h0, 32'h1004, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    total_cnt++;
    if (ras_hit !== 1'b0 || ras_count !== 3'd0 || ras_top !== 32'h0 || pc !== 32'h1004)
      $display("FAIL ovf_ret_4: hit=%b cnt=%0d top=%h pc=%h expected 0/0/0/1004",
               ras_hit, ras_count, ras_top, pc);
    else pass_cnt++;
  endtask

  task automatic test_replace();
    goto(32'h500);
    drive(JALR, 32'h0, 32'h600, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    total_cnt++;
    if (pc !== 32'h600 || ras_count !== 3'd1 || ras_top !== 32'h504)
      $display("FAIL repl_empty: pc=%h cnt=%0d top=%h expected 600/1/504", pc, ras_count, ras_top);
    else pass_cnt++;
    drive(JALR, 32'h0, 32'h700, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    total_cnt++;
    if (pc !== 32'h700 || ras_count !== 3'd1 || ras_top !== 32'h604 || ras_hit !== 1'b0)
      $display("FAIL repl: pc=%h cnt=%0d top=%h hit=%b expected 700/1/604/0",
               pc, ras_count, ras_top, ras_hit);
    else pass_cnt++;
    drive(JALR, 32'h0, 32'h800, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    total_cnt++;
    if (pc !== 32'h800 || ras_count !== 3'd0 || ras_hit !== 1'b0)
      $display("FAIL pop_miss: pc=%h cnt=%0d hit=%b expected 800/0/0", pc, ras_count, ras_hit);
    else pass_cnt++;
    drive(JALR, 32'h0, 32'h900, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    total_cnt++;
    if (pc !== 32'h900 || ras_count !== 3'd0 || ras_hit !== 1'b0)
      $display("FAIL pop_empty: pc=%h cnt=%0d hit=%b expected 900/0/0", pc, ras_count, ras_hit);
    else pass_cnt++;
  endtask

  task automatic test_hold_wrap();
    drive(JAL, 32'h10, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    total_cnt++;
    if (pc !== 32'h910 || ras_count !== 3'd1)
      $display("FAIL hold_setup: pc=%h cnt=%0d expected 910/1", pc, ras_count);
    else pass_cnt++;
    for (int c = 0; c < 3; c++) begin
      drive(JAL, 32'h10, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      total_cnt++;
      if (pc !== 32'h910 || ras_count !== 3'd1 || ras_top !== 32'h904)
        $display("FAIL hold_%0d: pc=%h cnt=%0d top=%h expected 910/1/904", c, pc, ras_count, ras_top);
      else pass_cnt++;
    end
    goto(32'hFFFF_FFFC);
    drive(NEXT, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    total_cnt++;
    if (pc !== 32'h0 || misalign !== 1'b0 || ras_count !== 3'd1)
      $display("FAIL wrap: pc=%h mis=%b cnt=%0d expected 0/0/1", pc, misalign, ras_count);
    else pass_cnt++;
  endtask

  task automatic test_misalign_reset();
    drive(JALR, 32'h0, 32'h302, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    total_cnt++;
    if (pc !== 32'h302 || misalign !== 1'b1)
      $display("FAIL misalign: pc=%h mis=%b expected 302/1", pc, misalign);
    else pass_cnt++;
    drive(NEXT, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    total_cnt++;
    if (misalign !== 1'b1 || pc !== 32'h302)
      $display("FAIL mis_hold: mis=%b pc=%h expected 1/302", misalign, pc);
    else pass_cnt++;
    // JALR clears bit 0 of rs1+imm: 0x401 -> 0x400, aligned.
    drive(JALR, 32'h1, 32'h400, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    total_cnt++;
    if (pc !== 32'h400 || misalign !== 1'b0)
      $display("FAIL jalr_bit0: pc=%h mis=%b expected 400/0", pc, misalign);
    else pass_cnt++;
    drive(JAL, 32'h20, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    drive(JAL, 32'h20, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    total_cnt++;
    if (pc !== 32'h440 || ras_count !== 3'd3 || ras_top !== 32'h424)
      $display("FAIL pre_rst: pc=%h cnt=%0d top=%h expected 440/3/424", pc, ras_count, ras_top);
    else pass_cnt++;
    RST = 1'b1;
    drive(JAL, 32'h20, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    total_cnt++;
    if (pc !== 32'h0 || ras_count !== 3'd0 || ras_top !== 32'h0)
      $display("FAIL mid_rst: pc=%h cnt=%0d top=%h expected 0/0/0", pc, ras_count, ras_top);
    else pass_cnt++;
    RST = 1'b0;
    drive(NEXT, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    total_cnt++;
    if (pc !== 32'h4 || ras_count !== 3'd0)
      $display("FAIL after_rst: pc=%h cnt=%0d expected 4/0", pc, ras_count);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_call_return();
    test_branches();
    test_ras_overflow();
    test_replace();
    test_hold_wrap();
    test_misalign_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule : tb_pc_ras_unit

// File: doc/pc_ras_unit.md
PC_RAS_UNIT -- requirements
Module: pc_ras_unit

Interface
REQ-001 Parameter XLEN, default 32, address and data width.
REQ-002 Parameter RESET_VEC, default 32'h0000_0000, PC value after reset.
REQ-003 Parameter RAS_DEPTH, default 4, return-address-stack entries; must be a power of two, at least 2.
REQ-004 Ports SHALL be:
- clk  in  1  single clock; all state updates on its rising edge.
- RST  in  1  synchronous, active-high reset.
- iready  in  1  instruction memory ready; PC and RAS advance only when 1.
- op  in  pc_op_t  NEXT, JAL, JALR, BEQ, BNE, BLT, BGE.
- rs1_read  in  XLEN  rs1 register value.
- imm  in  XLEN  sign-extended immediate.
- zero  in  1  ALU zero flag.
- negative  in  1  ALU negative flag.
- rd_is_ra  in  1  rd is x1 or x5.
- rs1_is_ra  in  1  rs1 is x1 or x5.
- pc  out  XLEN  current PC, registered.
- pc_plus4  out  XLEN  pc+4, the link value, combinational.
- ras_top  out  XLEN  top RAS entry; 0 when the stack is empty.
- ras_count  out  $clog2(RAS_DEPTH)+1  number of valid entries.
- ras_hit  out  1  registered one-cycle pulse: the last return matched its prediction.
- misalign  out  1  registered: the last committed target had bits [1:0] not equal to 0.

Function
REQ-005 The block SHALL compute target combinationally:
- NEXT: pc+4.
- JAL: pc+imm.
- JALR: (rs1_read+imm) with bit 0 cleared.
- BEQ: pc+imm if zero=1.
- BNE: pc+imm if zero=0.
- BLT: pc+imm if negative=1.
- BGE: pc+imm if negative=0.
- Any not-taken branch: pc+4.
REQ-006 All additions SHALL wrap modulo 2^XLEN and raise no overflow indication.
REQ-007 A cycle with iready=1 is a commit: pc SHALL equal target one cycle later (latency 1).
REQ-008 A cycle with iready=0 SHALL hold pc and the RAS, clear ras_hit, and hold misalign.
REQ-009 A commit of JAL or JALR with rd_is_ra=1 SHALL push pc_plus4, unless REQ-011 applies.
REQ-010 A commit of JALR with rs1_is_ra=1 and rd_is_ra=0 SHALL pop the top entry.
REQ-011 A commit of JALR with rs1_is_ra=1 and rd_is_ra=1 SHALL replace the top entry with pc_plus4, leaving ras_count unchanged; if the stack is empty, this is a plain push.
REQ-012 A push when ras_count=RAS_DEPTH SHALL overwrite the oldest entry (circular), with ras_count saturating at RAS_DEPTH.
REQ-013 A pop when ras_count=0 SHALL change nothing and leave ras_hit at 0.
REQ-014 ras_hit SHALL be 1 in the cycle after a non-empty pop whose target equals the popped entry, and 0 otherwise.
REQ-015 misalign SHALL update on every commit from target[1:0]; pc still loads the misaligned target.
REQ-016 op values outside the enumeration SHALL behave as NEXT.

Reset
REQ-017 While RST=1 at a rising edge:
- pc SHALL be set to RESET_VEC.
- ras_count, ras_hit and misalign SHALL be set to 0.
- RAS entry contents are don't-care.
REQ-018 RST SHALL take priority over iready and op; a push or pop in the same cycle as RST SHALL be discarded.
REQ-019 The first commit after RST falls SHALL use pc=RESET_VEC.

Structure
REQ-020 Package pc_pkg SHALL hold the pc_op_t enum, 3-bit encoded, and the constant INST_BYTES=4.
REQ-021 The RAS SHALL be the sub-module ras_stack, parameterised by XLEN and RAS_DEPTH, with push, pop, replace, wdata, top and count ports.
REQ-022 pc_ras_unit SHALL contain only the target mux, the branch-resolve logic, the pc register and the ras_hit/misalign registers.

Verification
REQ-023 Assert RST for 2 cycles with iready=1 and op=JAL -> pc=0, ras_count=0 and ras_hit=0 during RST, and for the first cycle after it.
REQ-024 At pc=0x100, apply op=JAL, imm=0x40, rd_is_ra=1 -> pc=0x140, ras_top=0x104, ras_count=1; then apply JALR, rs1_read=0x104, imm=0, rs1_is_ra=1 -> pc=0x104, ras_count=0, ras_hit=1 for one cycle.
REQ-025 At pc=0x200, apply BEQ with imm=-8: zero=1 -> pc=0x1F8; zero=0 -> pc=0x204. Repeat for BLT/BGE with negative toggled.
REQ-026 Perform 5 calls at RAS_DEPTH=4 -> ras_count=4 and the oldest link is lost; then perform 5 returns -> the first 4 give ras_hit=1, the 5th leaves ras_count=0 and gives ras_hit=0.
REQ-027 Hold iready=0 for 3 cycles with op=JAL, rd_is_ra=1 -> pc and ras_count unchanged; with pc=0xFFFF_FFFC and op=NEXT, commit -> pc=0 (wrap).
REQ-028 Apply JALR with rs1_read=0x302, imm=0 -> pc=0x302, misalign=1 on the next cycle; assert RST mid-stream after 2 pushes -> ras_count=0 and pc=RESET_VEC.
